// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS timer: digit radix rule and seven-segment patterns.
// The segment encoder is pure combinational and adds no latency.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

    // Even positions are units (0..9), odd positions are tens (0..5).
    function automatic int radix(input int i);
        return ((i % 2) == 0) ? 10 : 6;
    endfunction

    function automatic logic [6:0] seg_encode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of a ripple up/down chain with clamped parallel load.
// Value updates on the edge where load or carry-in is high; carry-out is combinational.
module bcd_digit_counter
    import timer_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic down_i,
    input  logic cin_i,
    output bcd_t value_o,
    output logic cout_o,
    output logic is_max_o,
    output logic is_zero_o
);

    localparam bcd_t MAXV = bcd_t'(RADIX - 1);

    bcd_t value_q;
    bcd_t value_d;

    assign is_max_o  = (value_q == MAXV);
    assign is_zero_o = (value_q == '0);
    assign cout_o    = cin_i & (down_i ? is_zero_o : is_max_o);
    assign value_o   = value_q;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = (load_val_i > MAXV) ? MAXV : load_val_i;
        end else if (cin_i) begin
            if (down_i) begin
                value_d = is_zero_o ? MAXV : value_q - 1'b1;
            end else begin
                value_d = is_max_o ? '0 : value_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/timer_disp_mux.sv
// Up/down MM:SS timer with a scanned seven-segment driver, all on one clock.
// Count changes on the sampling edge; seg/dig lag the scan index and count by one cycle.
module timer_disp_mux
    import timer_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                run,
    input  logic                dir,
    input  logic                load,
    input  logic [4*NDIG-1:0]   preset,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     dig,
    output logic [4*NDIG-1:0]   digits,
    output logic                zero,
    output logic                done,
    output logic                wrap
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NDIG > 2) ? $clog2(NDIG) : 1;

    bcd_t [NDIG-1:0]  val;
    logic [NDIG:0]    carry;
    logic [NDIG-1:0]  is_max;
    logic [NDIG-1:0]  is_zero;
    logic [NDIG-1:0]  upper_zero;
    logic             step;
    logic             one_left;
    logic             done_d;
    logic             wrap_d;

    logic [PW-1:0]    presc_q, presc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             presc_wrap;
    logic [6:0]       seg_q, seg_d;
    logic [NDIG-1:0]  dig_q, dig_d;
    logic             done_q, wrap_q;
    logic             blank;

    // Load wins over counting; a down step at all-zero is suppressed so the count holds.
    assign step     = run & tick & ~load;
    assign carry[0] = step & ~(dir & zero);

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit_counter #(
            .RADIX(radix(i))
        ) u_digit (
            .clk_i      (clk),
            .rst_ni     (rst),
            .load_i     (load),
            .load_val_i (preset[4*i +: 4]),
            .down_i     (dir),
            .cin_i      (carry[i]),
            .value_o    (val[i]),
            .cout_o     (carry[i+1]),
            .is_max_o   (is_max[i]),
            .is_zero_o  (is_zero[i])
        );
        assign digits[4*i +: 4] = val[i];
    end

    assign zero     = &is_zero;
    assign one_left = (val[0] == 4'd1) & (&is_zero[NDIG-1:1]);
    assign done_d   = carry[0] & dir & one_left;
    assign wrap_d   = carry[NDIG] & ~dir & (&is_max);

    always_comb begin
        upper_zero = '0;
        upper_zero[NDIG-1] = is_zero[NDIG-1];
        for (int i = NDIG - 2; i >= 0; i--) begin
            upper_zero[i] = is_zero[i] & upper_zero[i+1];
        end
    end

    assign presc_wrap = (presc_q == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        dig_d        = '0;
        dig_d[idx_q] = 1'b1;
        blank        = blank_lz & (idx_q != '0) & upper_zero[idx_q];
        seg_d        = blank ? SEG_BLANK : seg_encode(val[idx_q]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            dig_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign seg  = seg_q;
    assign dig  = dig_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_timer_disp_mux.sv
// Bench for timer_disp_mux with NDIG=4, SCAN_DIV=4: count model scoreboard plus scan/blanking checks.
module tb_timer_disp_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic [15:0] digits;
    logic        zero;
    logic        done;
    logic        wrap;

    timer_disp_mux #(.NDIG(4), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .run      (run),
        .dir      (dir),
        .load     (load),
        .preset   (preset),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dig      (dig),
        .digits   (digits),
        .zero     (zero),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic        done;
        logic        wrap;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   mval = 0;
    int   ecnt = 0;
    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Edges since reset release; slot index after edge k is ((k-1)/4)%4.
    always @(posedge clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    function automatic int clamp_val(input logic [15:0] p);
        int d[4];
        logic [15:0] pp;
        pp = p;
        for (int i = 0; i < 4; i++) begin
            d[i] = int'(pp[4*i +: 4]);
            if (d[i] > (((i % 2) == 0) ? 9 : 5)) d[i] = ((i % 2) == 0) ? 9 : 5;
        end
        return d[0] + 10 * d[1] + 60 * d[2] + 600 * d[3];
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 600), 4'((v / 60) % 10), 4'((v / 10) % 6), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input int v, input logic blk);
        int d[4];
        logic allz;
        d[0] = v % 10;
        d[1] = (v / 10) % 6;
        d[2] = (v / 60) % 10;
        d[3] = v / 600;
        allz = 1'b1;
        for (int j = idx; j < 4; j++) if (d[j] != 0) allz = 1'b0;
        if (blk && idx > 0 && allz) return 7'h00;
        return pat[d[idx]];
    endfunction

    // Drive one cycle of stimulus and queue the model's view of the result.
    task automatic cyc(input logic ld, input logic [15:0] pre, input logic tk);
        exp_t e;
        @(negedge clk);
        load = ld;
        preset = pre;
        tick = tk;
        e.done = 1'b0;
        e.wrap = 1'b0;
        if (ld) begin
            mval = clamp_val(pre);
        end else if (run && tk) begin
            if (!dir) begin
                if (mval == 3599) begin
                    mval = 0;
                    e.wrap = 1'b1;
                end else begin
                    mval++;
                end
            end else if (mval > 0) begin
                mval--;
                if (mval == 0) e.done = 1'b1;
            end
        end
        e.digits = to_bcd(mval);
        e.zero = (mval == 0);
        sb.push_back(e);
        @(posedge clk);
        #2;
        load = 1'b0;
        tick = 1'b0;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("digits", 32'(digits), 32'(e.digits));
            check("done", 32'(done), 32'(e.done));
            check("wrap", 32'(wrap), 32'(e.wrap));
            check("zero", 32'(zero), 32'(e.zero));
        end
    end

    task automatic scan_check(input string tag, input int n);
        int idx;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            idx = ((ecnt - 1) / 4) % 4;
            check({tag, "_dig"}, 32'(dig), 32'(1 << idx));
            check({tag, "_seg"}, 32'(seg), 32'(exp_seg(idx, mval, blank_lz)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_dig", 32'(dig), 32'h0);
        check("rst_zero", 32'(zero), 32'h1);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_flags", 32'({done, wrap}), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        scan_check("idle", 16);

        // Up count across the 59:59 rollover.
        run = 1'b1;
        dir = 1'b0;
        cyc(1'b1, 16'h5958, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0);

        // Down count to zero, then hold at zero.
        dir = 1'b1;
        cyc(1'b1, 16'h0100, 1'b0);
        for (int i = 0; i < 60; i++) cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 16'h0000, 1'b1);

        // Clamp on load, and load beats a simultaneous tick.
        cyc(1'b1, 16'hFFFF, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0);

        // Ticks ignored while run is low.
        run = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1);
        run = 1'b1;

        // Leading-zero blanking at 0007 and at 0000.
        blank_lz = 1'b1;
        cyc(1'b1, 16'h0007, 1'b0);
        scan_check("blank7", 16);
        for (int i = 0; i < 7; i++) cyc(1'b0, 16'h0000, 1'b1);
        scan_check("blank0", 16);
        blank_lz = 1'b0;

        // Reset asserted mid-slot with a nonzero count.
        cyc(1'b1, 16'h1234, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_digits", 32'(digits), 32'h0);
        check("mid_rst_seg", 32'(seg), 32'h0);
        check("mid_rst_dig", 32'(dig), 32'h0);
        check("mid_rst_zero", 32'(zero), 32'h1);
        check("mid_rst_flags", 32'({done, wrap}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_disp_mux.md
# timer_disp_mux

Parametrised MM:SS-style timer with a built-in multiplexed seven-segment driver. It extends the fixed four-digit up-only stopwatch in three ways: digit count is a parameter, it counts up or down, and it supports preset load, terminal-count flags and leading-zero blanking. It sits between the 1 Hz tick generator and the board display pins. Display scanning runs from the single system clock through an internal prescaler; no second clock is used.

## Interface
- NDIG, 4: number of digits; even, 2..8. Digit i has radix 10 when i is even and radix 6 when i is odd (i=0 is the least-significant digit).
- SCAN_DIV, 1000: clk cycles per display scan slot; at least 2.
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  count strobe, one clk wide (e.g. 1 Hz).
- run  in  1  count gate; a tick is ignored while run=0.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  loads preset on this edge.
- preset  in  4*NDIG  BCD preset; digit i is in bits [4i+3:4i].
- blank_lz  in  1  enables leading-zero blanking.
- seg  out  7  segments a..g on seg[0]..seg[6], active-high, registered.
- dig  out  NDIG  one-hot digit enable, active-high, registered.
- digits  out  4*NDIG  current BCD count, registered.
- zero  out  1  all digits are 0 (combinational from the count).
- done  out  1  one-cycle pulse: a down count has reached zero.
- wrap  out  1  one-cycle pulse: an up count has rolled over from its maximum.

## Operation
- Reset state:
  - digits = 0, scan index = 0, prescaler = 0.
  - seg = 0, dig = 0, done = 0, wrap = 0, zero = 1.
- Count priority on each edge: load > (run & tick) > hold.
- Load:
  - Each preset digit ≥ its radix is clamped to radix-1 (e.g. 4'hF becomes 9 or 5).
  - Load never raises done or wrap.
- Up count:
  - Digit 0 increments. A digit at radix-1 wraps to 0 and carries into the next digit.
  - The carry ripples through the whole chain in the same cycle.
  - When every digit is at its maximum (e.g. 59:59), the count goes to all-zero and wrap pulses.
- Down count:
  - Digit 0 decrements. A digit at 0 borrows and reloads radix-1.
  - At all-zero the count holds: no borrow, no wrap, no pulse.
  - The tick that takes a nonzero count to zero pulses done.
- Flag timing: done and wrap are registered and high for exactly one cycle after the edge that caused them.
- Changing dir between ticks takes effect on the next tick.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At the terminal value it returns to 0 and the scan index advances, wrapping NDIG-1 → 0.
- Display register (updated every cycle):
  - dig = one-hot of the scan index.
  - seg = 7-segment pattern of digits[index] at that instant.
  - Patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
- Blanking: seg = 0 for index i > 0 when blank_lz=1 and digits i..NDIG-1 are all 0. Digit 0 is never blanked.

## Timing
- Count latency: digits changes on the edge where load, or run&tick, is sampled high.
- Display latency: seg and dig reflect the current index and count one cycle later.
- Slot length: each digit is lit for SCAN_DIV cycles; a full refresh takes NDIG*SCAN_DIV cycles.
- First display output: the first nonzero dig appears on the first edge after rst deasserts.
- Asserting rst mid-count or mid-scan clears all state immediately, including any pending done/wrap pulse.
- Prescaler width is $clog2(SCAN_DIV). The scan index width is $clog2(NDIG), minimum 1.

## Structure
- Shared package (timer_pkg) holds:
  - radix function: radix(i) = 10 for even i, 6 for odd i;
  - seven-segment pattern constants and the blank value;
  - BCD digit type (4 bits).
- Sub-module bcd_digit_counter, one instance per digit via generate:
  - inputs: RADIX parameter, load value, up/down, carry/borrow in;
  - outputs: value, carry/borrow out, is_max, is_zero.
- The top level holds the prescaler, scan index, blanking mask, flag registers and output registers.

## Test plan
- Reset and idle, NDIG=4, SCAN_DIV=4:
  - during reset: seg=0, dig=0, zero=1;
  - after release: dig steps 0001→0010→0100→1000 every 4 cycles; seg=3F in every slot while blank_lz=0.
- Up count with wrap: load 59:58, run=1, dir=0, two ticks → digits 5959, then 0000 with wrap high for exactly 1 cycle; done stays 0.
- Down count to zero: load 01:00, dir=1, tick → 0059; after 59 more ticks → 0000 with one done pulse; further ticks keep 0000 with no pulse.
- Load clamp and priority: preset FFFF with load and tick in the same cycle → digits 5959, no flag pulse.
- Blanking: count 0007, blank_lz=1 → slots 1..3 show seg=0 and slot 0 shows 07; at count 0000 slot 0 shows 3F.
- Gating and reset mid-run:
  - ticks with run=0 leave the count unchanged;
  - rst asserted mid-slot at count 1234 → all outputs return to reset values within the same cycle.
